// File: rtl/text_line_gen.sv
// VGA text-line overlay: a row of NUM_CHARS 8x16 glyphs at (X0,Y0) with power-of-two
// magnification, per-character blink and a writable character buffer. Three-stage pipeline.
module text_line_gen #(
    parameter int NUM_CHARS  = 8,
    parameter int X0         = 0,
    parameter int Y0         = 0,
    parameter int SCALE_LOG2 = 0,
    parameter int BLINK_LOG2 = 5
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        video_on_i,
    input  logic [9:0]  pixel_x_i,
    input  logic [9:0]  pixel_y_i,
    input  logic        frame_tick_i,
    input  logic        wr_en_i,
    input  logic [5:0]  wr_addr_i,
    input  logic [7:0]  wr_data_i,
    input  logic [2:0]  rgb_sw_i,
    output logic [10:0] font_addr_o,
    input  logic [7:0]  font_data_i,
    output logic        text_on_o,
    output logic [2:0]  rgb_text_o
);

    localparam int AW    = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam int DEPTH = 2 ** AW;

    // Window bounds carried at 12 bits so X0+W never wraps for the widest legal window.
    localparam logic [11:0] X_LO = 12'(X0);
    localparam logic [11:0] X_HI = 12'(X0 + ((NUM_CHARS * 8) << SCALE_LOG2));
    localparam logic [11:0] Y_LO = 12'(Y0);
    localparam logic [11:0] Y_HI = 12'(Y0 + (16 << SCALE_LOG2));

    logic [7:0]            buf_q [DEPTH];
    logic [BLINK_LOG2-1:0] blink_cnt_q, blink_cnt_d;

    logic [11:0] px, py, dx, dy;
    logic        hit;
    logic [7:0]  entry;
    logic        buf_wr;

    logic [10:0] font_addr_q, font_addr_d;
    logic        blink_s1_q, blink_s1_d;
    logic        hit_s1_q, von_s1_q;
    logic [2:0]  col_s1_q;
    logic        blink_s2_q, hit_s2_q, von_s2_q;
    logic [2:0]  col_s2_q;
    logic        text_on_q, text_on_d;
    logic [2:0]  rgb_q, rgb_d;
    logic        pix;
    logic        unused_bits;

    always_comb begin
        px          = {2'b00, pixel_x_i};
        py          = {2'b00, pixel_y_i};
        hit         = (px >= X_LO) && (px < X_HI) && (py >= Y_LO) && (py < Y_HI);
        dx          = (px - X_LO) >> SCALE_LOG2;
        dy          = (py - Y_LO) >> SCALE_LOG2;
        entry       = buf_q[dx[AW+2:3]];
        font_addr_d = hit ? {entry[6:0], dy[3:0]} : 11'd0;
        blink_s1_d  = hit && entry[7];
        buf_wr      = wr_en_i && ({1'b0, wr_addr_i} < 7'(NUM_CHARS));
        blink_cnt_d = frame_tick_i ? blink_cnt_q + 1'b1 : blink_cnt_q;
    end

    // Blink suppression uses the phase current at S3; a tick mid-pipeline moves at most a pixel.
    always_comb begin
        pix       = font_data_i[3'd7 - col_s2_q] && !(blink_s2_q && blink_cnt_q[BLINK_LOG2-1]);
        text_on_d = von_s2_q && hit_s2_q;
        rgb_d     = (von_s2_q && hit_s2_q && pix) ? rgb_sw_i : 3'b000;
    end

    assign unused_bits = ^{dx, dy};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= 8'h00;
        end else if (buf_wr) begin
            buf_q[wr_addr_i[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            blink_cnt_q <= '0;
            font_addr_q <= '0;
            blink_s1_q  <= 1'b0;
            hit_s1_q    <= 1'b0;
            von_s1_q    <= 1'b0;
            col_s1_q    <= '0;
            blink_s2_q  <= 1'b0;
            hit_s2_q    <= 1'b0;
            von_s2_q    <= 1'b0;
            col_s2_q    <= '0;
            text_on_q   <= 1'b0;
            rgb_q       <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            font_addr_q <= font_addr_d;
            blink_s1_q  <= blink_s1_d;
            hit_s1_q    <= hit;
            von_s1_q    <= video_on_i;
            col_s1_q    <= dx[2:0];
            blink_s2_q  <= blink_s1_q;
            hit_s2_q    <= hit_s1_q;
            von_s2_q    <= von_s1_q;
            col_s2_q    <= col_s1_q;
            text_on_q   <= text_on_d;
            rgb_q       <= rgb_d;
        end
    end

    assign font_addr_o = font_addr_q;
    assign text_on_o   = text_on_q;
    assign rgb_text_o  = rgb_q;

endmodule

// File: tb/tb_text_line_gen.sv
// Directed bench for text_line_gen: three instances with different window/scale parameters
// share stimulus, each fed by its own synchronous font ROM model.
module tb_text_line_gen;

    logic        clk = 1'b0;
    logic        reset, video_on, frame_tick, wr_en;
    logic [9:0]  pixel_x, pixel_y;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [2:0]  rgb_sw;

    logic [10:0] fa_a, fa_b, fa_c;
    logic [7:0]  fd_a, fd_b, fd_c;
    logic        on_a, on_b, on_c;
    logic [2:0]  rgb_a, rgb_b, rgb_c;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [10:0] a);
        case (a[10:4])
            7'h41:   return 8'h81;
            7'h42:   return 8'hFF;
            7'h43:   return 8'h3C;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        fd_a <= rom(fa_a);
        fd_b <= rom(fa_b);
        fd_c <= rom(fa_c);
    end

    text_line_gen #(.NUM_CHARS(8), .X0(0), .Y0(0), .SCALE_LOG2(0), .BLINK_LOG2(2)) dut_a (
        .clk_i(clk), .reset_i(reset), .video_on_i(video_on), .pixel_x_i(pixel_x),
        .pixel_y_i(pixel_y), .frame_tick_i(frame_tick), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .rgb_sw_i(rgb_sw), .font_addr_o(fa_a), .font_data_i(fd_a),
        .text_on_o(on_a), .rgb_text_o(rgb_a));

    text_line_gen #(.NUM_CHARS(8), .X0(16), .Y0(8), .SCALE_LOG2(0), .BLINK_LOG2(5)) dut_b (
        .clk_i(clk), .reset_i(reset), .video_on_i(video_on), .pixel_x_i(pixel_x),
        .pixel_y_i(pixel_y), .frame_tick_i(frame_tick), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .rgb_sw_i(rgb_sw), .font_addr_o(fa_b), .font_data_i(fd_b),
        .text_on_o(on_b), .rgb_text_o(rgb_b));

    text_line_gen #(.NUM_CHARS(8), .X0(16), .Y0(8), .SCALE_LOG2(1), .BLINK_LOG2(5)) dut_c (
        .clk_i(clk), .reset_i(reset), .video_on_i(video_on), .pixel_x_i(pixel_x),
        .pixel_y_i(pixel_y), .frame_tick_i(frame_tick), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .rgb_sw_i(rgb_sw), .font_addr_o(fa_c), .font_data_i(fd_c),
        .text_on_o(on_c), .rgb_text_o(rgb_c));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pixel(input int x, input int y);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
    endtask

    task automatic step3();
        step(); step(); step();
    endtask

    task automatic write_slot(input logic [5:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; video_on = 1'b1; frame_tick = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; rgb_sw = 3'b010;
        set_pixel(0, 3);
        step(); step();
        total++;
        if ({fa_a, on_a, rgb_a} !== 15'd0)
            $display("FAIL reset_outputs: got fa=%h on=%b rgb=%b, want all zero", fa_a, on_a, rgb_a);
        else passed++;
        reset = 1'b0;
        step3();
        total++;
        if (fa_a !== 11'h003)
            $display("FAIL reset_buffer_clear: font_addr=%h want 003", fa_a);
        else passed++;
    endtask

    task automatic test_basic();
        write_slot(6'd0, 8'h41);
        rgb_sw = 3'b010; video_on = 1'b1;
        set_pixel(0, 3);
        step();
        total++;
        if (fa_a !== {7'h41, 4'd3})
            $display("FAIL basic_font_addr: got %h want %h", fa_a, {7'h41, 4'd3});
        else passed++;
        step(); step();
        total++;
        if (rgb_a !== 3'b010 || on_a !== 1'b1)
            $display("FAIL basic_rgb_on: got rgb=%b on=%b want 010/1", rgb_a, on_a);
        else passed++;
        set_pixel(1, 3);
        step3();
        total++;
        if (rgb_a !== 3'b000 || on_a !== 1'b1)
            $display("FAIL basic_rgb_off: got rgb=%b on=%b want 000/1", rgb_a, on_a);
        else passed++;
    endtask

    // Back-to-back pixels, one per clock; result of vector i appears after step i+2.
    task automatic test_window_edges();
        int xs [7] = '{15, 80, 20, 16, 79, 20, 20};
        int ys [7] = '{10, 10, 24, 10, 10, 8, 23};
        logic ex [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 9; i++) begin
            if (i < 7) set_pixel(xs[i], ys[i]);
            step();
            if (i >= 2) begin
                total++;
                if (on_b !== ex[i-2])
                    $display("FAIL window_edge(%0d,%0d): text_on=%b want %b",
                             xs[i-2], ys[i-2], on_b, ex[i-2]);
                else passed++;
            end
        end
    endtask

    task automatic test_scale();
        write_slot(6'd1, 8'h42);
        set_pixel(16, 14);
        step3();
        total++;
        if (rgb_c !== 3'b010) $display("FAIL scale_x0_col0: rgb=%b want 010", rgb_c);
        else passed++;
        set_pixel(17, 14);
        step3();
        total++;
        if (rgb_c !== 3'b010) $display("FAIL scale_x1_col0: rgb=%b want 010", rgb_c);
        else passed++;
        set_pixel(18, 14);
        step3();
        total++;
        if (rgb_c !== 3'b000) $display("FAIL scale_x2_col1: rgb=%b want 000", rgb_c);
        else passed++;
        set_pixel(32, 39);
        step();
        total++;
        if (fa_c !== {7'h42, 4'hF})
            $display("FAIL scale_slot1_row15: font_addr=%h want %h", fa_c, {7'h42, 4'hF});
        else passed++;
    endtask

    task automatic test_blink();
        write_slot(6'd2, 8'hC1);
        set_pixel(16, 3);
        step3();
        total++;
        if (rgb_a !== 3'b010) $display("FAIL blink_before: rgb=%b want 010", rgb_a);
        else passed++;
        tick(); tick();
        step3();
        total++;
        if (rgb_a !== 3'b000) $display("FAIL blink_hidden: rgb=%b want 000", rgb_a);
        else passed++;
        set_pixel(0, 3);
        step3();
        total++;
        if (rgb_a !== 3'b010) $display("FAIL blink_slot0_draws: rgb=%b want 010", rgb_a);
        else passed++;
        tick(); tick();
        set_pixel(16, 3);
        step3();
        total++;
        if (rgb_a !== 3'b010) $display("FAIL blink_visible_again: rgb=%b want 010", rgb_a);
        else passed++;
    endtask

    task automatic test_write_collision();
        set_pixel(8, 3);
        wr_en = 1'b1; wr_addr = 6'd1; wr_data = 8'h43;
        step();
        wr_en = 1'b0;
        total++;
        if (fa_a !== {7'h42, 4'd3})
            $display("FAIL collide_old: font_addr=%h want %h", fa_a, {7'h42, 4'd3});
        else passed++;
        step();
        total++;
        if (fa_a !== {7'h43, 4'd3})
            $display("FAIL collide_new: font_addr=%h want %h", fa_a, {7'h43, 4'd3});
        else passed++;
        write_slot(6'd8, 8'h55);
        set_pixel(0, 3);
        step();
        total++;
        if (fa_a !== {7'h41, 4'd3})
            $display("FAIL oob_slot0: font_addr=%h want %h", fa_a, {7'h41, 4'd3});
        else passed++;
        set_pixel(56, 3);
        step();
        total++;
        if (fa_a !== {7'h00, 4'd3})
            $display("FAIL oob_slot7: font_addr=%h want %h", fa_a, {7'h00, 4'd3});
        else passed++;
        set_pixel(100, 3);
        step();
        total++;
        if (fa_a !== 11'd0)
            $display("FAIL outside_font_addr: font_addr=%h want 000", fa_a);
        else passed++;
    endtask

    task automatic test_video_off_and_reset();
        video_on = 1'b0;
        set_pixel(0, 3);
        step3();
        total++;
        if (rgb_a !== 3'b000 || on_a !== 1'b0)
            $display("FAIL video_off: rgb=%b on=%b want 000/0", rgb_a, on_a);
        else passed++;
        video_on = 1'b1;
        step3();
        total++;
        if (rgb_a !== 3'b010 || on_a !== 1'b1)
            $display("FAIL pre_reset_active: rgb=%b on=%b want 010/1", rgb_a, on_a);
        else passed++;
        reset = 1'b1;
        step();
        total++;
        if ({fa_a, on_a, rgb_a} !== 15'd0)
            $display("FAIL midline_reset: fa=%h on=%b rgb=%b want all zero", fa_a, on_a, rgb_a);
        else passed++;
        reset = 1'b0;
        step();
        total++;
        if (on_a !== 1'b0 || rgb_a !== 3'b000)
            $display("FAIL reset_flush: on=%b rgb=%b want 0/000", on_a, rgb_a);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_window_edges();
        test_scale();
        test_blink();
        test_write_collision();
        test_video_off_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
